// File: rtl/ras_checker.sv
// Shadow return-address-stack checker: pops call/return records from the trace
// FIFO and checks every return target against the address its call pushed.
module ras_checker #(
    parameter int STACK_DEPTH = 32,
    parameter int CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          clear,
    input  logic                          fifo_empty,
    input  logic [35:0]                   fifo_dout,
    output logic                          fifo_pop,
    output logic [$clog2(STACK_DEPTH):0]  sp,
    output logic [CNT_W-1:0]              ret_cnt,
    output logic [CNT_W-1:0]              mismatch_cnt,
    output logic                          overflow,
    output logic                          underflow,
    output logic                          mismatch,
    output logic [31:0]                   exp_addr,
    output logic [31:0]                   got_addr,
    output logic                          idle
);
    localparam int AW = $clog2(STACK_DEPTH);
    localparam logic [3:0] OP_CALL  = 4'h1;
    localparam logic [3:0] OP_RET   = 4'h2;
    localparam logic [3:0] OP_FLUSH = 4'h3;
    localparam logic [AW:0] SP_FULL = (AW+1)'(STACK_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0] stack [STACK_DEPTH];
    logic [35:0] rec_q;
    logic        rec_v;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [AW:0] sp_m1;
    logic [31:0] top;
    logic        is_call;
    logic        is_ret;
    logic        is_flush;
    logic        push_ok;
    logic        pop_ok;
    logic        ret_miss;

    // Pop handshake: the FIFO head is consumed on every rising edge where
    // fifo_pop is high; fifo_dout must be valid whenever fifo_empty is low.
    assign fifo_pop = rst_n & enable & ~fifo_empty & ~clear;
    assign idle     = ~rec_v & (fifo_empty | ~enable);

    assign op    = rec_q[35:32];
    assign addr  = rec_q[31:0];
    assign sp_m1 = sp - 1'b1;
    assign top   = stack[sp_m1[AW-1:0]];

    always_comb begin
        is_call  = rec_v && (op == OP_CALL);
        is_ret   = rec_v && (op == OP_RET);
        is_flush = rec_v && (op == OP_FLUSH);
        push_ok  = is_call && (sp != SP_FULL);
        pop_ok   = is_ret && (sp != '0);
        ret_miss = pop_ok && (top != addr);
    end

    // Storage has no reset; sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            stack[sp[AW-1:0]] <= addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_v <= 1'b0;
            rec_q <= '0;
        end else begin
            rec_v <= fifo_pop;
            if (fifo_pop) begin
                rec_q <= fifo_dout;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp           <= '0;
            ret_cnt      <= '0;
            mismatch_cnt <= '0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            mismatch     <= 1'b0;
            exp_addr     <= '0;
            got_addr     <= '0;
        end else if (clear) begin
            sp           <= '0;
            ret_cnt      <= '0;
            mismatch_cnt <= '0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            mismatch     <= 1'b0;
            exp_addr     <= '0;
            got_addr     <= '0;
        end else begin
            mismatch <= ret_miss;
            if (push_ok) begin
                sp <= sp + 1'b1;
            end else if (pop_ok) begin
                sp <= sp_m1;
            end else if (is_flush) begin
                sp <= '0;
            end
            if (is_call && !push_ok) begin
                overflow <= 1'b1;
            end
            if (is_ret && !pop_ok) begin
                underflow <= 1'b1;
            end
            if (pop_ok && (ret_cnt != CNT_MAX)) begin
                ret_cnt <= ret_cnt + 1'b1;
            end
            if (ret_miss) begin
                if (mismatch_cnt != CNT_MAX) begin
                    mismatch_cnt <= mismatch_cnt + 1'b1;
                end
                exp_addr <= top;
                got_addr <= addr;
            end
        end
    end
endmodule

// File: doc/ras_checker.md
# ras_checker

Downstream consumer of the trace FIFO: pops 36-bit call/return records whenever the FIFO is non-empty and replays them against an internal shadow return-address stack. Every return's target is checked against the address the matching call pushed. Mismatches, stack overflow and stack underflow are reported through saturating counters, sticky flags and a per-event pulse carrying both addresses. The block is the checking end of the RAS test path and has no backpressure beyond its `enable` input.

## Interface
Parameters:
- `STACK_DEPTH`, 32, shadow stack entries; power of two, ≥ 2.
- `CNT_W`, 16, width of each statistics counter.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `enable`  in  1  allows records to be popped.
- `clear`  in  1  synchronous clear of stack, counters, flags and pipeline.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_dout`  in  36  FIFO head record; valid while `fifo_empty`=0.
- `fifo_pop`  out  1  pops the FIFO head this cycle.
- `sp`  out  $clog2(STACK_DEPTH)+1  current stack depth.
- `ret_cnt`  out  CNT_W  returns checked.
- `mismatch_cnt`  out  CNT_W  returns whose target differed.
- `overflow`  out  1  sticky; a call was dropped because the stack was full.
- `underflow`  out  1  sticky; a return arrived with an empty stack.
- `mismatch`  out  1  one-cycle pulse per mismatching return.
- `exp_addr`  out  32  stack-top address of the last mismatch.
- `got_addr`  out  32  record address of the last mismatch.
- `idle`  out  1  no record in flight and nothing poppable.

## Operation
- Record format:
  - `[35:32]` opcode: 4'h1 CALL, 4'h2 RET, 4'h3 FLUSH; every other opcode is a NOP.
  - `[31:0]` address.
- Stage 0 (pop):
  - `fifo_pop = enable & ~fifo_empty & ~clear`, combinational.
  - When `fifo_pop`=1, `fifo_dout` is registered into `rec_q` and `rec_v` is set to 1.
  - Otherwise `rec_v` is set to 0.
- Stage 1 (execute) runs when `rec_v`=1, one record per cycle:
  - CALL, `sp`<STACK_DEPTH: write `stack[sp]` = address, then `sp` increments.
  - CALL, `sp`=STACK_DEPTH: the record is dropped, `overflow` is set, `sp` is unchanged.
  - RET, `sp`=0: `underflow` is set; `ret_cnt` is unchanged and no compare is made.
  - RET, `sp`>0: compare `stack[sp-1]` with the address, decrement `sp`, increment `ret_cnt`.
  - RET compare differs: increment `mismatch_cnt`, pulse `mismatch`, load `exp_addr` = `stack[sp-1]` and `got_addr` = the record address.
  - FLUSH: `sp` is set to 0; nothing is counted.
  - NOP: no effect.
- The stack read is combinational from the stack storage. A CALL's write is visible to a RET executed on the next cycle, so there is no hazard and no stall.
- Counters saturate at all-ones and never wrap.
- `exp_addr` and `got_addr` hold their value until the next mismatch or a clear.
- `clear` (priority over all other activity):
  - `sp`, both counters, both flags, `mismatch`, `exp_addr`, `got_addr` and `rec_v` are set to 0.
  - A record in flight is discarded unexecuted.
  - Stack contents are don't-care.
- Deasserting `enable` stops popping only. A record already in `rec_q` still executes.
- `idle = ~rec_v & (fifo_empty | ~enable)`.

## Timing
- Reset (`rst_n`=0, asynchronous) forces all of the following to 0:
  - `sp`, `ret_cnt`, `mismatch_cnt`, `overflow`, `underflow`, `mismatch`, `exp_addr`, `got_addr`, `rec_v`.
- During reset `fifo_pop` = 0, and `idle` follows its equation.
- Reset asserted mid-stream loses the in-flight record. The FIFO pointer has already advanced for it.
- Latency for a record popped in cycle N:
  - Executes in cycle N+1.
  - `sp`, the counters and the flags reflect it in cycle N+2.
  - `mismatch` is high for exactly cycle N+2.
- Throughput is one record per cycle sustained, so `fifo_pop` can stay high continuously.
- Back-to-back mismatches produce a continuous `mismatch` high, one cycle per event, and `mismatch_cnt` increments on each.

## Test plan
- Reset, then push CALL 0x1000 and RET 0x1000 → `fifo_pop` high for 2 cycles; `sp` goes 1 then 0; `ret_cnt`=1, `mismatch_cnt`=0, `mismatch` never high.
- Push CALL 0xA0, CALL 0xB0, RET 0xA0 → one `mismatch` pulse 2 cycles after the RET pop; `exp_addr`=0xB0, `got_addr`=0xA0, `mismatch_cnt`=1, `sp`=1.
- With STACK_DEPTH=4, push 5 CALLs then 4 matching RETs → `overflow`=1 after the 5th CALL; `sp` peaks at 4; returns check against the first 4 addresses; `mismatch_cnt`=0.
- RET on an empty stack, then FLUSH after 3 CALLs → `underflow`=1 and `ret_cnt`=0; after the FLUSH executes, `sp`=0.
- Deassert `enable` with 3 records queued → `fifo_pop`=0; the in-flight record still executes; `idle`=1 one cycle later. Reassert → the remaining 2 records pop back-to-back.
- Assert `clear` for 1 cycle while a record is in `rec_q`, and separately drop `rst_n` asynchronously mid-stream → the record is discarded; all counters, flags and `sp` read 0 on the next cycle.
